// File: rtl/uart_rx_if.sv
// Processor-side bus of the UART receiver: FIFO head, pop strobe and sticky error flags.
interface uart_rx_if;
  logic [7:0] UART_data;
  logic       UART_empty;
  logic       UART_rd;
  logic       UART_framing_error;
  logic       UART_overflow;
  logic       UART_clr_err;

  modport master (
    input  UART_data,
    input  UART_empty,
    input  UART_framing_error,
    input  UART_overflow,
    output UART_rd,
    output UART_clr_err
  );

  modport slave (
    output UART_data,
    output UART_empty,
    output UART_framing_error,
    output UART_overflow,
    input  UART_rd,
    input  UART_clr_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM and a small receive FIFO
// with a registered head output and sticky framing/overflow flags.
module uart_rx #(
  parameter int G_BAUD_DIVIDE = 868,
  parameter int G_SYNC_STAGES = 3,
  parameter int G_FIFO_DEPTH  = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_UART_Rx,
  uart_rx_if.slave  io_bus
);

  localparam int C_TW = $clog2(G_BAUD_DIVIDE);
  localparam int C_PW = $clog2(G_FIFO_DEPTH);
  localparam logic [C_TW-1:0] C_HALF    = C_TW'(G_BAUD_DIVIDE / 2 - 1);
  localparam logic [C_TW-1:0] C_FULL    = C_TW'(G_BAUD_DIVIDE - 1);
  localparam logic [C_PW:0]   C_PTR_ONE = (C_PW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [G_SYNC_STAGES-1:0] r_sync;
  logic                     r_rx_prev;
  state_t                   r_state;
  logic [C_TW-1:0]          r_timer;
  logic [2:0]               r_bit_cnt;
  logic [7:0]               r_shreg;
  logic                     r_framing_error;

  logic [7:0]               r_mem [G_FIFO_DEPTH];
  logic [C_PW:0]            r_wr_ptr;
  logic [C_PW:0]            r_rd_ptr;
  logic [7:0]               r_data;
  logic                     r_overflow;

  logic                     w_rx_s;
  logic                     w_expire;
  logic                     w_push;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_push_ok;
  logic [C_PW:0]            w_rd_next;
  logic [C_PW:0]            w_wr_next;

  assign w_rx_s   = r_sync[G_SYNC_STAGES-1];
  assign w_expire = (r_timer == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[G_SYNC_STAGES-2:0], i_UART_Rx};
      r_rx_prev <= w_rx_s;
    end
  end

  // Clear is applied first so a framing error in the same cycle still wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_timer         <= '0;
      r_bit_cnt       <= '0;
      r_shreg         <= '0;
      r_framing_error <= 1'b0;
    end else begin
      if (io_bus.UART_clr_err) begin
        r_framing_error <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (r_rx_prev && !w_rx_s) begin
            r_timer <= C_HALF;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_expire) begin
            if (w_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_timer   <= C_FULL;
              r_bit_cnt <= '0;
              r_state   <= S_DATA;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_DATA: begin
          if (w_expire) begin
            r_shreg   <= {w_rx_s, r_shreg[7:1]};
            r_timer   <= C_FULL;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_STOP: begin
          if (w_expire) begin
            if (!w_rx_s) begin
              r_framing_error <= 1'b1;
            end
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_push    = (r_state == S_STOP) && w_expire && w_rx_s;
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[C_PW] != r_rd_ptr[C_PW]) &&
                     (r_wr_ptr[C_PW-1:0] == r_rd_ptr[C_PW-1:0]);
  assign w_pop     = io_bus.UART_rd && !w_empty;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_rd_next = w_pop     ? r_rd_ptr + C_PTR_ONE : r_rd_ptr;
  assign w_wr_next = w_push_ok ? r_wr_ptr + C_PTR_ONE : r_wr_ptr;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[C_PW-1:0]] <= r_shreg;
    end
  end

  // The new head is the byte being pushed only when it lands in the slot the read pointer moves to.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      if (w_rd_next != w_wr_next) begin
        r_data <= (w_push_ok && (w_rd_next == r_wr_ptr)) ? r_shreg
                                                         : r_mem[w_rd_next[C_PW-1:0]];
      end
      if (io_bus.UART_clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign io_bus.UART_data          = r_data;
  assign io_bus.UART_empty         = w_empty;
  assign io_bus.UART_framing_error = r_framing_error;
  assign io_bus.UART_overflow      = r_overflow;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames queue their expected bytes, and a
// monitor pops and compares every byte the receiver presents.
module tb_uart_rx;

  localparam int BAUD = 32;

  logic clk = 1'b0;
  logic rst;
  logic rxLine;
  logic [7:0] expQ[$];
  int vectors = 0;
  int miscompares = 0;
  bit autoPop = 1'b1;

  uart_rx_if bus ();

  uart_rx #(
    .G_BAUD_DIVIDE(BAUD),
    .G_SYNC_STAGES(3),
    .G_FIFO_DEPTH (4)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_UART_Rx(rxLine),
    .io_bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    rxLine = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxLine = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rxLine = stopBit;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit expectPush);
    if (expectPush) expQ.push_back(b);
    sendFrame(b, 1'b1);
  endtask

  task automatic idleBits(input int n);
    rxLine = 1'b1;
    repeat (n * BAUD) @(negedge clk);
  endtask

  task automatic pulseClear();
    bus.UART_clr_err = 1'b1;
    @(negedge clk);
    bus.UART_clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitDrain(input string name);
    int cyc = 0;
    while ((expQ.size() != 0 || !bus.UART_empty) && cyc < 20 * BAUD) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(name, expQ.size(), 0);
    checkOutput({name, "Empty"}, bus.UART_empty, 1'b1);
  endtask

  // Monitor: pops each presented byte and compares it with the scoreboard head.
  initial begin
    bus.UART_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (autoPop && !rst && !bus.UART_empty) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpectedByte: got %0h, expected no byte", bus.UART_data);
        end else begin
          checkOutput("rxByte", bus.UART_data, expQ.pop_front());
        end
        bus.UART_rd = 1'b1;
        @(negedge clk);
        bus.UART_rd = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string msg;
    msg = "Hello world!\r\n";
    rst = 1'b1;
    rxLine = 1'b1;
    bus.UART_clr_err = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetEmpty", bus.UART_empty, 1'b1);
    checkOutput("resetData", bus.UART_data, 8'h00);
    checkOutput("resetFraming", bus.UART_framing_error, 1'b0);
    checkOutput("resetOverflow", bus.UART_overflow, 1'b0);
    rst = 1'b0;
    idleBits(2);

    // Single byte: 3 sync flops + edge register, then half a bit plus nine bits to the stop sample.
    fork
      applyStimulus(8'h48, 1'b1);
      begin
        repeat (4 + BAUD / 2 + 9 * BAUD - 1) @(posedge clk);
        #1 checkOutput("emptyBeforeStop", bus.UART_empty, 1'b1);
        @(posedge clk);
        #1 checkOutput("emptyAfterStop", bus.UART_empty, 1'b0);
        checkOutput("firstData", bus.UART_data, 8'h48);
      end
    join
    waitDrain("singleByte");
    checkOutput("singleFraming", bus.UART_framing_error, 1'b0);
    checkOutput("singleOverflow", bus.UART_overflow, 1'b0);

    // Back-to-back string with no idle gap.
    for (int i = 0; i < msg.len(); i++) applyStimulus(msg[i], 1'b1);
    waitDrain("helloString");
    checkOutput("helloFraming", bus.UART_framing_error, 1'b0);
    checkOutput("helloOverflow", bus.UART_overflow, 1'b0);

    // Overflow: five bytes into a four-deep FIFO with no reads.
    autoPop = 1'b0;
    for (int b = 1; b <= 5; b++) applyStimulus(8'(b), b <= 4);
    idleBits(1);
    checkOutput("overflowSet", bus.UART_overflow, 1'b1);
    checkOutput("fullNotEmpty", bus.UART_empty, 1'b0);
    checkOutput("fullHead", bus.UART_data, 8'h01);
    pulseClear();
    checkOutput("overflowCleared", bus.UART_overflow, 1'b0);
    autoPop = 1'b1;
    waitDrain("overflowDrain");

    // Framing error, then recovery after one idle bit.
    sendFrame(8'h55, 1'b0);
    idleBits(1);
    checkOutput("framingSet", bus.UART_framing_error, 1'b1);
    checkOutput("framingNoPush", bus.UART_empty, 1'b1);
    applyStimulus(8'hA3, 1'b1);
    waitDrain("afterFraming");
    pulseClear();
    checkOutput("framingCleared", bus.UART_framing_error, 1'b0);

    // False start: low pulse shorter than half a bit.
    rxLine = 1'b0;
    repeat (BAUD / 4) @(negedge clk);
    idleBits(2);
    checkOutput("falseStartEmpty", bus.UART_empty, 1'b1);
    checkOutput("falseStartFraming", bus.UART_framing_error, 1'b0);
    checkOutput("falseStartOverflow", bus.UART_overflow, 1'b0);
    applyStimulus(8'h00, 1'b1);
    waitDrain("afterFalseStart");

    // Reset at mid-bit 4 while the line is low; the partial byte must not appear.
    rxLine = 1'b0;
    repeat (5 * BAUD + BAUD / 2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("midResetEmpty", bus.UART_empty, 1'b1);
    rst = 1'b0;
    repeat (12 * BAUD) @(negedge clk);
    idleBits(2);
    checkOutput("midResetNoPush", bus.UART_empty, 1'b1);
    pulseClear();
    checkOutput("midResetFramingCleared", bus.UART_framing_error, 1'b0);
    applyStimulus(8'h3C, 1'b1);
    waitDrain("afterMidReset");
    checkOutput("finalOverflow", bus.UART_overflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
